// File: rtl/l2_window_gen.sv
// Streams sliding KxK windows over the pooled IMG_WxIMG_W map held in L2_out1.
// A single raster read pass feeds a shift-chain line buffer; windows emerge 2 cycles after their last address.
module l2_window_gen #(
  parameter int DATA_W = 12,
  parameter int IMG_W  = 14,
  parameter int K      = 5,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pool_done,
  input  logic [DATA_W-1:0]        L2_out1_dout,
  output logic [ADDR_W-1:0]        L2_out1_addr_read2,
  output logic                     L2_out1_en,
  output logic [K*K*DATA_W-1:0]    win_data,
  output logic                     win_valid,
  output logic [3:0]               win_row,
  output logic [3:0]               win_col,
  output logic                     busy,
  output logic                     gen_done
);

  localparam int SR_LEN = (K-1)*IMG_W + K;
  localparam int CW     = 4;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t            state;
  logic              pool_done_d;
  logic [CW-1:0]     x;
  logic [CW-1:0]     y;
  logic              drain_cnt;

  logic              tag_valid;
  logic [CW-1:0]     tag_x;
  logic [CW-1:0]     tag_y;
  logic              win_gate;

  logic [DATA_W-1:0]        sr [SR_LEN];
  logic [K*K*DATA_W-1:0]    win_next;

  assign L2_out1_addr_read2 = ADDR_W'(x) + ADDR_W'(y) * ADDR_W'(IMG_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pool_done_d <= 1'b1;
      x           <= '0;
      y           <= '0;
      drain_cnt   <= 1'b0;
      L2_out1_en  <= 1'b0;
      busy        <= 1'b0;
      gen_done    <= 1'b0;
    end else begin
      pool_done_d <= pool_done;
      gen_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (pool_done && !pool_done_d) begin
            state      <= READ;
            L2_out1_en <= 1'b1;
            busy       <= 1'b1;
            x          <= '0;
            y          <= '0;
          end
        end
        READ: begin
          // Counters stop on the last pixel so the address holds through DRAIN.
          if (x == CW'(IMG_W-1)) begin
            if (y == CW'(IMG_W-1)) begin
              state      <= DRAIN;
              L2_out1_en <= 1'b0;
              drain_cnt  <= 1'b0;
            end else begin
              x <= '0;
              y <= y + 1'b1;
            end
          end else begin
            x <= x + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state    <= DONE;
            gen_done <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          x     <= '0;
          y     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign win_gate = tag_valid && (tag_x >= CW'(K-1)) && (tag_y >= CW'(K-1));

  // Taps are taken from the chain as it will look after this edge's shift,
  // so the newest pixel comes straight from the read data.
  always_comb begin
    win_next = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        if ((K-1-i)*IMG_W + (K-1-j) == 0)
          win_next[(i*K+j)*DATA_W +: DATA_W] = L2_out1_dout;
        else
          win_next[(i*K+j)*DATA_W +: DATA_W] = sr[(K-1-i)*IMG_W + (K-1-j) - 1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tag_valid) begin
      sr[0] <= L2_out1_dout;
      for (int unsigned k = 1; k < SR_LEN; k++) sr[k] <= sr[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= 1'b0;
      tag_x     <= '0;
      tag_y     <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_data  <= '0;
    end else begin
      tag_valid <= (state == READ);
      tag_x     <= x;
      tag_y     <= y;
      win_valid <= win_gate;
      if (win_gate) begin
        win_data <= win_next;
        win_row  <= tag_y - CW'(K-1);
        win_col  <= tag_x - CW'(K-1);
      end
    end
  end

endmodule

// File: tb/tb_l2_window_gen.sv
// Scoreboard bench for l2_window_gen: driver queues expected windows per pass,
// a negedge monitor compares every presented window plus pass timing.
module tb_l2_window_gen;
  localparam int DATA_W = 12;
  localparam int IMG_W  = 14;
  localparam int K      = 5;
  localparam int ADDR_W = 8;
  localparam int NPIX   = IMG_W*IMG_W;
  localparam int WV     = K*K*DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pool_done = 1'b0;
  logic [DATA_W-1:0] dout = '0;
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic [WV-1:0]     win_data;
  logic              win_valid;
  logic [3:0]        win_row;
  logic [3:0]        win_col;
  logic              busy;
  logic              gen_done;

  always #5 clk = ~clk;

  l2_window_gen #(.DATA_W(DATA_W), .IMG_W(IMG_W), .K(K), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .pool_done(pool_done), .L2_out1_dout(dout),
    .L2_out1_addr_read2(addr), .L2_out1_en(en), .win_data(win_data),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .gen_done(gen_done)
  );

  typedef struct packed {
    logic [3:0]    row;
    logic [3:0]    col;
    logic [WV-1:0] data;
  } win_t;

  logic [DATA_W-1:0] mem [NPIX];
  win_t q[$];
  int checks = 0;
  int failures = 0;

  // monitor state
  bit in_pass = 0;
  int n = 0;
  int wcount = 0;
  logic [WV-1:0] cap_first, cap_r1c0, cap_last;

  always @(posedge clk) if (en && addr < NPIX) dout <= mem[addr];

  task automatic chk(input string name, input logic [WV-1:0] act, input logic [WV-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] tap(input logic [WV-1:0] w, input int i, input int j);
    return w[(i*K+j)*DATA_W +: DATA_W];
  endfunction

  task automatic fill(input int mode);
    for (int yy = 0; yy < IMG_W; yy++)
      for (int xx = 0; xx < IMG_W; xx++) begin
        case (mode)
          0:       mem[xx+yy*IMG_W] = DATA_W'(xx+yy*IMG_W);
          1:       mem[xx+yy*IMG_W] = 12'hFFF;
          default: mem[xx+yy*IMG_W] = ((xx+yy) % 2 == 1) ? 12'hFFF : 12'h000;
        endcase
      end
  endtask

  task automatic push_windows();
    win_t e;
    for (int r = 0; r < IMG_W-K+1; r++)
      for (int c = 0; c < IMG_W-K+1; c++) begin
        e.row = 4'(r);
        e.col = 4'(c);
        e.data = '0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            e.data[(i*K+j)*DATA_W +: DATA_W] = mem[(r+i)*IMG_W + (c+j)];
        q.push_back(e);
      end
  endtask

  task automatic run_pass(input bit ramp_checks);
    bit got;
    push_windows();
    @(posedge clk); #1 pool_done = 1'b1;
    @(negedge clk); chk("en_before_start", en, 0);
    @(negedge clk); chk("start_next_cycle", en, 1);
    got = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (gen_done) begin got = 1; break; end
    end
    chk("gen_done_seen", got, 1);
    @(negedge clk); pool_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    q.delete();
    if (ramp_checks) begin
      chk("first_tap00", tap(cap_first, 0, 0), 0);
      chk("first_tap04", tap(cap_first, 0, 4), 4);
      chk("first_tap40", tap(cap_first, 4, 0), 56);
      chk("first_tap44", tap(cap_first, 4, 4), 60);
      chk("r1c0_tap00",  tap(cap_r1c0, 0, 0), 14);
      chk("r1c0_tap44",  tap(cap_r1c0, 4, 4), 74);
      chk("last_tap00",  tap(cap_last, 0, 0), 135);
      chk("last_tap44",  tap(cap_last, 4, 4), 195);
    end
  endtask

  always @(negedge clk) begin
    win_t e;
    if (rst) begin
      in_pass = 0;
    end else begin
      if (!in_pass && en) begin
        in_pass = 1; n = 0; wcount = 0;
      end else if (in_pass) begin
        n++;
      end
      if (in_pass && n <= 198) begin
        chk("en_window", en, (n < 196) ? 1 : 0);
        chk("busy_in_pass", busy, 1);
        if (n < 196) chk("addr_seq", addr, n);
        else if (n < 198) chk("addr_hold", addr, 195);
      end
      if (win_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_window", win_valid, 0);
        end else begin
          e = q.pop_front();
          chk("win_row", win_row, e.row);
          chk("win_col", win_col, e.col);
          chk("win_data", win_data, e.data);
          if (win_row == 0 && win_col == 0) cap_first = win_data;
          if (win_row == 1 && win_col == 0) cap_r1c0 = win_data;
          if (win_row == 9 && win_col == 9) cap_last = win_data;
        end
        if (in_pass) begin
          if (wcount == 0) chk("first_win_cycle", n, 62);
          wcount++;
          if (wcount == 100) chk("last_win_cycle", n, 197);
        end
      end
      if (gen_done) begin
        chk("gen_done_cycle", (in_pass && n == 198) ? 1 : 0, 1);
        chk("win_count", wcount, 100);
      end
      if (in_pass && n == 199) begin
        chk("busy_low_after", busy, 0);
        chk("gen_done_single", gen_done, 0);
        in_pass = 0;
      end
    end
  end

  initial begin
    bit got;
    fill(0);
    pool_done = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", win_valid, 0);
    chk("rst_gen_done", gen_done, 0);
    chk("rst_addr", addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("held_level_no_start", {en, busy}, 0);
    end
    pool_done = 1'b0;
    repeat (2) @(negedge clk);

    fill(0); run_pass(1);
    fill(1); run_pass(0);
    fill(2); run_pass(0);

    // reset in the middle of a ramp pass
    fill(0);
    push_windows();
    @(posedge clk); #1 pool_done = 1'b1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (en) begin got = 1; break; end
    end
    chk("midrst_pass_started", got, 1);
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_en", en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", win_valid, 0);
    chk("midrst_gen_done", gen_done, 0);
    q.delete();
    @(posedge clk); #1 rst = 1'b0; pool_done = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("midrst_quiet", {en, win_valid, gen_done, busy}, 0);
    end
    run_pass(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
